// File: rtl/card_pkg.sv
// Card codes and active-low 7-segment patterns, shared by the card encoder and seg7card decoder.
package card_pkg;

  localparam logic [3:0] CARD_BLANK = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_TWO   = 4'd2;
  localparam logic [3:0] CARD_THREE = 4'd3;
  localparam logic [3:0] CARD_FOUR  = 4'd4;
  localparam logic [3:0] CARD_FIVE  = 4'd5;
  localparam logic [3:0] CARD_SIX   = 4'd6;
  localparam logic [3:0] CARD_SEVEN = 4'd7;
  localparam logic [3:0] CARD_EIGHT = 4'd8;
  localparam logic [3:0] CARD_NINE  = 4'd9;
  localparam logic [3:0] CARD_TEN   = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;
  localparam logic [3:0] CARD_BAD   = 4'd15;

  // Segment patterns, bit6 = g .. bit0 = a, 0 = lit
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ACE   = 7'h08;
  localparam logic [6:0] SEG_TWO   = 7'h24;
  localparam logic [6:0] SEG_THREE = 7'h30;
  localparam logic [6:0] SEG_FOUR  = 7'h19;
  localparam logic [6:0] SEG_FIVE  = 7'h12;
  localparam logic [6:0] SEG_SIX   = 7'h02;
  localparam logic [6:0] SEG_SEVEN = 7'h78;
  localparam logic [6:0] SEG_EIGHT = 7'h00;
  localparam logic [6:0] SEG_NINE  = 7'h10;
  localparam logic [6:0] SEG_TEN   = 7'h40;
  localparam logic [6:0] SEG_JACK  = 7'h61;
  localparam logic [6:0] SEG_QUEEN = 7'h18;
  localparam logic [6:0] SEG_KING  = 7'h09;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } card_state_t;

  // Returns {bad, code}
  function automatic logic [4:0] seg_to_card(input logic [6:0] seg);
    logic [4:0] r;
    r = {1'b0, CARD_BLANK};
    case (seg)
      SEG_BLANK: r = {1'b0, CARD_BLANK};
      SEG_ACE:   r = {1'b0, CARD_ACE};
      SEG_TWO:   r = {1'b0, CARD_TWO};
      SEG_THREE: r = {1'b0, CARD_THREE};
      SEG_FOUR:  r = {1'b0, CARD_FOUR};
      SEG_FIVE:  r = {1'b0, CARD_FIVE};
      SEG_SIX:   r = {1'b0, CARD_SIX};
      SEG_SEVEN: r = {1'b0, CARD_SEVEN};
      SEG_EIGHT: r = {1'b0, CARD_EIGHT};
      SEG_NINE:  r = {1'b0, CARD_NINE};
      SEG_TEN:   r = {1'b0, CARD_TEN};
      SEG_JACK:  r = {1'b0, CARD_JACK};
      SEG_QUEEN: r = {1'b0, CARD_QUEEN};
      SEG_KING:  r = {1'b0, CARD_KING};
      default:   r = {1'b1, CARD_BAD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Holds the last sampled segment pattern and flags it once unchanged for STABLE_CYCLES clocks.
module seg_stable_filter
  import card_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  output logic [6:0] seg_q,
  output logic       stable
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      seg_q    <= SEG_BLANK;
      stab_cnt <= '0;
    end else if (seg_in == seg_q) begin
      if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CW'(1);
    end else begin
      seg_q    <= seg_in;
      stab_cnt <= CW'(1);
    end
  end

  assign stable = (stab_cnt == CNT_MAX);

endmodule

// File: rtl/seg7card.sv
// Recovers card codes from a 7-segment display pattern and offers them on valid/ready.
// Define SEG7CARD_ACTIVE_HIGH_EN to accept an active-high (1 = lit) seg_in.
module seg7card
  import card_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  output logic [3:0] card_out,
  output logic       card_valid,
  input  logic       card_ready,
  output logic       bad_pattern
);

  logic [6:0]  seg_n;
  logic [6:0]  seg_q;
  logic        stable;
  logic [6:0]  last_seg;
  logic [4:0]  dec;
  card_state_t state;

`ifdef SEG7CARD_ACTIVE_HIGH_EN
  assign seg_n = ~seg_in;
`else
  assign seg_n = seg_in;
`endif

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .resetb (resetb),
    .seg_in (seg_n),
    .seg_q  (seg_q),
    .stable (stable)
  );

  assign dec = seg_to_card(seg_q);

  // Evaluation only happens in IDLE, so an offer always follows at least one idle cycle
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      last_seg    <= SEG_BLANK;
      card_out    <= CARD_BLANK;
      bad_pattern <= 1'b0;
      card_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stable && (seg_q != last_seg)) begin
            card_out    <= dec[3:0];
            bad_pattern <= dec[4];
            last_seg    <= seg_q;
            card_valid  <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (card_ready) begin
            card_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7card.sv
// Scoreboard bench for seg7card: expected {bad,code} queued on stimulus, popped on each handshake.
module tb_seg7card;

  logic       clk = 1'b0;
  logic       resetb;
  logic [6:0] seg_in;
  logic [3:0] card_out;
  logic       card_valid;
  logic       card_ready;
  logic       bad_pattern;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [4:0]  sb[$];

  // Bench-local decode table, index = card code
  logic [6:0] pat [14] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                           7'b0011000, 7'b0001001};

  seg7card #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .seg_in     (seg_in),
    .card_out   (card_out),
    .card_valid (card_valid),
    .card_ready (card_ready),
    .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake monitor: a transfer completes on the next edge whenever valid && ready here
  always @(negedge clk) begin
    if (resetb && card_valid && card_ready) begin
      if (sb.size() == 0) begin
        check("spurious_offer", {27'd0, bad_pattern, card_out}, 32'h1F);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        check("offer", {27'd0, bad_pattern, card_out}, {27'd0, e});
      end
    end
  end

  initial begin
    bit held_ok;
    resetb     = 1'b0;
    seg_in     = 7'h7F;
    card_ready = 1'b1;
    #12;
    check("rst_valid", card_valid, 0);
    check("rst_out", card_out, 0);
    check("rst_bad", bad_pattern, 0);
    resetb = 1'b1;

    // Blank held from reset: no offer
    tick(20);
    check("blank_valid", card_valid, 0);
    check("blank_out", card_out, 0);

    // Ace latency: valid rises exactly at E0+4
    seg_in = pat[1];
    sb.push_back({1'b0, 4'd1});
    tick(4);
    check("ace_early", card_valid, 0);
    tick(1);
    check("ace_valid", card_valid, 1);
    check("ace_out", card_out, 1);
    tick(1);
    check("ace_drop", card_valid, 0);
    tick(20);
    check("ace_norepeat", card_valid, 0);

    // Held offer with a pattern settling behind it
    card_ready = 1'b0;
    seg_in = pat[3];
    sb.push_back({1'b0, 4'd3});
    tick(5);
    check("three_valid", card_valid, 1);
    seg_in = pat[11];
    sb.push_back({1'b0, 4'd11});
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!(card_valid && card_out == 4'd3 && !bad_pattern)) held_ok = 1'b0;
    end
    check("three_held", held_ok, 1);
    card_ready = 1'b1;
    tick(1);
    check("three_accept", card_valid, 0);
    card_ready = 1'b0;
    tick(1);
    check("jack_valid", card_valid, 1);
    check("jack_out", card_out, 11);
    card_ready = 1'b1;
    tick(2);

    // Glitch back to the last accepted value
    seg_in = pat[8];
    sb.push_back({1'b0, 4'd8});
    tick(8);
    seg_in = pat[9];
    tick(2);
    seg_in = pat[8];
    tick(10);
    check("glitch_none", card_valid, 0);

    // Unrecognised pattern, then blank
    card_ready = 1'b0;
    seg_in = 7'b1010101;
    sb.push_back({1'b1, 4'd15});
    tick(5);
    check("bad_valid", card_valid, 1);
    check("bad_out", card_out, 15);
    check("bad_flag", bad_pattern, 1);
    card_ready = 1'b1;
    tick(1);
    seg_in = pat[0];
    sb.push_back({1'b0, 4'd0});
    tick(8);
    check("blank2_out", card_out, 0);
    check("blank2_bad", bad_pattern, 0);

    // Walk the whole table
    for (int i = 1; i < 14; i++) begin
      seg_in = pat[i];
      sb.push_back({1'b0, 4'(i)});
      tick(8);
    end
    seg_in = pat[0];
    sb.push_back({1'b0, 4'd0});
    tick(8);

    // Async reset during a pending King offer
    card_ready = 1'b0;
    seg_in = pat[13];
    sb.push_back({1'b0, 4'd13});
    tick(5);
    check("king_valid", card_valid, 1);
    check("king_out", card_out, 13);
    #2;
    resetb = 1'b0;
    #1;
    check("arst_valid", card_valid, 0);
    check("arst_out", card_out, 0);
    check("arst_bad", bad_pattern, 0);
    void'(sb.pop_back());
    tick(2);
    resetb = 1'b1;
    tick(2);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
